acia_uart: RTL and testbench

- Parametrised 6551-style ACIA for the Dragon 64 / CoCo serial port; register-compatible successor to the fixed-value serial stub.
- Real 8N1 transmit and receive with a programmable 16x-oversampled baud generator, a RX FIFO of configurable depth, status/IRQ logic and a CPU register interface.
- Sits on the CPU bus decode at the serial-port address window; txd/rxd go to the top-level UART pins.

---
 rtl/acia_pkg.sv | 30 +++
 rtl/acia_if.sv | 14 +
 rtl/acia_fifo.sv | 53 +++++
 rtl/acia_uart.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_acia_uart.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acia_pkg.sv
// Shared constants and FSM state types for the 6551-style ACIA.
package acia_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CMD    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int unsigned ST_PARITY  = 0;
  localparam int unsigned ST_FRAMING = 1;
  localparam int unsigned ST_OVERRUN = 2;
  localparam int unsigned ST_RDRF    = 3;
  localparam int unsigned ST_TDRE    = 4;
  localparam int unsigned ST_DCD     = 5;
  localparam int unsigned ST_DSR     = 6;
  localparam int unsigned ST_IRQ     = 7;

  localparam logic [7:0] STATUS_RST = 8'h10;
  localparam logic [7:0] CMD_RST    = 8'h02;
  localparam logic [7:0] CTRL_RST   = 8'h00;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Clocks per 16x tick for a non-zero baud select.
  function automatic int unsigned tick_period(input int unsigned clk_div, input logic [3:0] sel);
    return clk_div * (32'd16 - 32'(sel));
  endfunction

endpackage

// File: rtl/acia_if.sv
// CPU register bus plus serial pins of the ACIA.
interface acia_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_n;
  logic       txd;
  logic       rxd;

  modport master (output cs, we, addr, din, rxd, input dout, irq_n, txd);
  modport slave  (input cs, we, addr, din, rxd, output dout, irq_n, txd);
endinterface

// File: rtl/acia_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module acia_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;
  assign o_rdata   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/acia_uart.sv
// 6551-style ACIA: 8N1 TX/RX, 16x baud generator, RX FIFO, status/IRQ and register interface.
// Optional ACIA_LOOPBACK_EN: command bit4 routes the TX stream into RX and holds txd high.
module acia_uart
  import acia_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 7,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 12
) (
  input logic  clk,
  input logic  reset_n,
  acia_if.slave bus
);

  logic w_wr_data, w_wr_status, w_wr_cmd, w_wr_ctrl, w_rd, w_rd_data;

  assign w_wr_data   = bus.cs & bus.we & (bus.addr == ADDR_DATA);
  assign w_wr_status = bus.cs & bus.we & (bus.addr == ADDR_STATUS);
  assign w_wr_cmd    = bus.cs & bus.we & (bus.addr == ADDR_CMD);
  assign w_wr_ctrl   = bus.cs & bus.we & (bus.addr == ADDR_CTRL);
  assign w_rd        = bus.cs & ~bus.we;
  assign w_rd_data   = w_rd & (bus.addr == ADDR_DATA);

  logic [7:0] r_cmd;
  logic [7:0] r_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd  <= CMD_RST;
      r_ctrl <= CTRL_RST;
    end else begin
      if (w_wr_cmd)         r_cmd <= bus.din;
      else if (w_wr_status) r_cmd <= {r_cmd[7:5], CMD_RST[4:0]};
      if (w_wr_ctrl)        r_ctrl <= bus.din;
    end
  end

  // Baud generator; select 0 halts it and with it both serial FSMs.
  logic [3:0]       w_sel;
  logic             w_run;
  logic             w_tick;
  logic [DIV_W-1:0] w_period_m1;
  logic [DIV_W-1:0] r_div_cnt;

  assign w_sel       = r_ctrl[3:0];
  assign w_run       = (w_sel != 4'd0);
  assign w_period_m1 = DIV_W'(tick_period(CLK_DIV, w_sel) - 32'd1);
  assign w_tick      = w_run & (r_div_cnt == w_period_m1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_div_cnt <= '0;
    else if (w_wr_ctrl) r_div_cnt <= '0;
    else if (w_tick)    r_div_cnt <= '0;
    else if (w_run)     r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  // Transmitter
  tx_state_e  r_tx_state, w_tx_state_d;
  logic [3:0] r_tx_tick, w_tx_tick_d;
  logic [2:0] r_tx_bit, w_tx_bit_d;
  logic [7:0] r_tx_shift, w_tx_shift_d;
  logic       w_tx_load;
  logic       w_tx_serial;
  logic       r_tx_line;
  logic [7:0] r_thr;
  logic       r_tdre;

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_tick_d  = r_tx_tick;
    w_tx_bit_d   = r_tx_bit;
    w_tx_shift_d = r_tx_shift;
    w_tx_load    = 1'b0;
    if (w_tick) begin
      unique case (r_tx_state)
        TxIdle: begin
          if (!r_tdre) begin
            w_tx_load    = 1'b1;
            w_tx_state_d = TxStart;
            w_tx_tick_d  = 4'd0;
          end
        end
        TxStart: begin
          w_tx_tick_d = r_tx_tick + 4'd1;
          if (r_tx_tick == 4'd15) begin
            w_tx_state_d = TxData;
            w_tx_bit_d   = 3'd0;
          end
        end
        TxData: begin
          w_tx_tick_d = r_tx_tick + 4'd1;
          if (r_tx_tick == 4'd15) begin
            w_tx_shift_d = {1'b1, r_tx_shift[7:1]};
            if (r_tx_bit == 3'd7) w_tx_state_d = TxStop;
            else                  w_tx_bit_d   = r_tx_bit + 3'd1;
          end
        end
        TxStop: begin
          w_tx_tick_d = r_tx_tick + 4'd1;
          if (r_tx_tick == 4'd15) begin
            // Reload straight into a start bit so back-to-back frames have no gap.
            if (!r_tdre) begin
              w_tx_load    = 1'b1;
              w_tx_state_d = TxStart;
            end else begin
              w_tx_state_d = TxIdle;
            end
          end
        end
        default: w_tx_state_d = TxIdle;
      endcase
    end
    if (w_tx_load) w_tx_shift_d = r_thr;
    if (w_wr_status) begin
      w_tx_state_d = TxIdle;
      w_tx_tick_d  = 4'd0;
      w_tx_bit_d   = 3'd0;
      w_tx_load    = 1'b0;
    end
  end

  always_comb begin
    w_tx_serial = 1'b1;
    if (w_tx_state_d == TxStart)     w_tx_serial = 1'b0;
    else if (w_tx_state_d == TxData) w_tx_serial = w_tx_shift_d[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TxIdle;
      r_tx_tick  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_tick  <= w_tx_tick_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx_shift <= w_tx_shift_d;
      r_tx_line  <= w_tx_serial;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_thr  <= 8'h00;
      r_tdre <= 1'b1;
    end else if (w_wr_status) begin
      r_tdre <= 1'b1;
    end else begin
      if (w_tx_load) r_tdre <= 1'b1;
      if (w_wr_data && r_tdre) begin
        r_thr  <= bus.din;
        r_tdre <= 1'b0;
      end
    end
  end

  // Receiver
  logic w_rx_in;

`ifdef ACIA_LOOPBACK_EN
  assign w_rx_in = r_cmd[4] ? r_tx_line : bus.rxd;
  assign bus.txd = r_cmd[4] ? 1'b1 : r_tx_line;
`else
  assign w_rx_in = bus.rxd;
  assign bus.txd = r_tx_line;
`endif

  logic       r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_e  r_rx_state, w_rx_state_d;
  logic [3:0] r_rx_tick, w_rx_tick_d;
  logic [2:0] r_rx_bit, w_rx_bit_d;
  logic [7:0] r_rx_shift, w_rx_shift_d;
  logic       w_rx_push;
  logic       w_rx_ferr;

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_tick_d  = r_rx_tick;
    w_rx_bit_d   = r_rx_bit;
    w_rx_shift_d = r_rx_shift;
    w_rx_push    = 1'b0;
    w_rx_ferr    = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        if (w_run && r_rx_prev && !r_rx_s2) begin
          w_rx_state_d = RxStart;
          w_rx_tick_d  = 4'd0;
        end
      end
      RxStart: begin
        if (w_tick) begin
          w_rx_tick_d = r_rx_tick + 4'd1;
          if (r_rx_tick == 4'd7) begin
            if (r_rx_s2) begin
              w_rx_state_d = RxIdle;
            end else begin
              w_rx_state_d = RxData;
              w_rx_tick_d  = 4'd0;
              w_rx_bit_d   = 3'd0;
            end
          end
        end
      end
      RxData: begin
        if (w_tick) begin
          w_rx_tick_d = r_rx_tick + 4'd1;
          if (r_rx_tick == 4'd15) begin
            w_rx_shift_d = {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) w_rx_state_d = RxStop;
            else                  w_rx_bit_d   = r_rx_bit + 3'd1;
          end
        end
      end
      RxStop: begin
        if (w_tick) begin
          w_rx_tick_d = r_rx_tick + 4'd1;
          if (r_rx_tick == 4'd15) begin
            w_rx_push    = 1'b1;
            w_rx_ferr    = ~r_rx_s2;
            w_rx_state_d = RxIdle;
          end
        end
      end
      default: w_rx_state_d = RxIdle;
    endcase
    if (w_wr_status) begin
      w_rx_state_d = RxIdle;
      w_rx_push    = 1'b0;
      w_rx_ferr    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_tick  <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1    <= w_rx_in;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_d;
      r_rx_tick  <= w_rx_tick_d;
      r_rx_bit   <= w_rx_bit_d;
      r_rx_shift <= w_rx_shift_d;
    end
  end

  logic [7:0] w_fifo_rdata;
  logic       w_fifo_full;
  logic       w_fifo_empty;

  acia_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (w_wr_status),
    .i_push  (w_rx_push),
    .i_pop   (w_rd_data),
    .i_wdata (w_rx_shift_d),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Status, errors, read data and IRQ
  logic       r_overrun;
  logic       r_framing;
  logic       r_irq_n;
  logic [7:0] r_dout;
  logic [7:0] w_status;
  logic       w_overrun_set;

  assign w_overrun_set = w_rx_push & w_fifo_full & ~w_rd_data;
  assign w_status = {~r_irq_n, 1'b0, 1'b0, r_tdre, ~w_fifo_empty, r_overrun, r_framing, 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
    end else if (w_wr_status) begin
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
    end else begin
      if (w_rd_data) begin
        r_overrun <= 1'b0;
        r_framing <= 1'b0;
      end
      if (w_overrun_set)         r_overrun <= 1'b1;
      if (w_rx_push & w_rx_ferr) r_framing <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout  <= 8'h00;
      r_irq_n <= 1'b1;
    end else begin
      r_irq_n <= ~((~w_fifo_empty & ~r_cmd[1]) | (r_tdre & (r_cmd[3:2] == 2'b01)));
      if (w_rd) begin
        unique case (bus.addr)
          ADDR_DATA:   r_dout <= w_fifo_empty ? 8'h00 : w_fifo_rdata;
          ADDR_STATUS: r_dout <= w_status;
          ADDR_CMD:    r_dout <= r_cmd;
          ADDR_CTRL:   r_dout <= r_ctrl;
          default:     r_dout <= 8'h00;
        endcase
      end
    end
  end

  assign bus.dout  = r_dout;
  assign bus.irq_n = r_irq_n;

endmodule

// File: tb/tb_acia_uart.sv
// Self-checking bench for acia_uart: register reads, TX framing/timing, RX FIFO scoreboard.
module tb_acia_uart;
  import acia_pkg::*;

  localparam int unsigned CLK_DIV    = 7;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BIT_CLKS   = CLK_DIV * 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic r_loop = 1'b0;
  logic r_rx_drv = 1'b1;

  acia_if bus ();
  assign bus.rxd = r_loop ? bus.txd : r_rx_drv;

  acia_uart #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (12)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int unsigned tx_starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0;
    d = bus.dout;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    r_rx_drv = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      r_rx_drv = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    r_rx_drv = stop;
    repeat (BIT_CLKS) @(negedge clk);
    r_rx_drv = 1'b1;
  endtask

  // Decodes one frame on txd and checks it against the head of tx_q; returns at mid stop bit.
  task automatic tx_frame(input string name);
    int unsigned n = 0;
    logic [7:0] got;
    logic [7:0] exp;
    while (bus.txd !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.txd !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_timeout got=%b exp=0", name, bus.txd);
      return;
    end
    tx_starts.push_back(cyc);
    repeat (BIT_CLKS - 1) @(negedge clk);
    checks++;
    if (bus.txd !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_len got=%b exp=0", name, bus.txd);
    end
    repeat (1 + BIT_CLKS / 2) @(negedge clk);
    got[0] = bus.txd;
    for (int i = 1; i < 8; i++) begin
      repeat (BIT_CLKS) @(negedge clk);
      got[i] = bus.txd;
    end
    repeat (BIT_CLKS) @(negedge clk);
    checks++;
    if (bus.txd !== 1'b1) begin
      failures++;
      $display("FAIL %s_stop got=%b exp=1", name, bus.txd);
    end
    exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s_data got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.din = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.irq_n !== 1'b1 || bus.txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_pins got=%b%b exp=11", bus.irq_n, bus.txd);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.dout !== 8'h00) begin
      failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout);
    end
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL reset_status got=%h exp=10", v); end
    bus_read(ADDR_CMD, v);
    checks++;
    if (v !== 8'h02) begin failures++; $display("FAIL reset_cmd got=%h exp=02", v); end
    bus_read(ADDR_CTRL, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", v); end
    bus_read(ADDR_DATA, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", v); end
  endtask

  task automatic test_tx();
    logic [7:0] v;
    fork
      tx_frame("tx55");
      begin
        bus_write(ADDR_CTRL, 8'h0F);
        bus_write(ADDR_DATA, 8'h55);
        tx_q.push_back(8'h55);
        bus_read(ADDR_STATUS, v);
        checks++;
        if (v[ST_TDRE] !== 1'b0) begin failures++; $display("FAIL tx_tdre_busy got=%b exp=0", v[ST_TDRE]); end
        repeat (5) @(negedge clk);
        bus_read(ADDR_STATUS, v);
        checks++;
        if (v[ST_TDRE] !== 1'b1) begin failures++; $display("FAIL tx_tdre_free got=%b exp=1", v[ST_TDRE]); end
      end
    join
    repeat (100) @(negedge clk);
  endtask

  task automatic test_freeze();
    logic [7:0] v;
    bus_write(ADDR_CTRL, 8'h00);
    bus_write(ADDR_DATA, 8'h5A);
    tx_q.push_back(8'h5A);
    repeat (300) @(negedge clk);
    bus_read(ADDR_STATUS, v);
    checks++;
    if (bus.txd !== 1'b1 || v[ST_TDRE] !== 1'b0) begin
      failures++; $display("FAIL freeze_hold got=txd%b tdre%b exp=txd1 tdre0", bus.txd, v[ST_TDRE]);
    end
    fork
      tx_frame("freeze5a");
      bus_write(ADDR_CTRL, 8'h0F);
    join
    repeat (100) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int unsigned gap;
    tx_starts.delete();
    fork
      begin
        tx_frame("b2b_a");
        tx_frame("b2b_b");
      end
      begin
        bus_write(ADDR_DATA, 8'h81);
        tx_q.push_back(8'h81);
        repeat (20) @(negedge clk);
        bus_write(ADDR_DATA, 8'h7E);
        tx_q.push_back(8'h7E);
      end
    join
    gap = (tx_starts.size() == 2) ? tx_starts[1] - tx_starts[0] : 0;
    checks++;
    if (gap !== 10 * BIT_CLKS) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, 10 * BIT_CLKS);
    end
    repeat (100) @(negedge clk);
  endtask

  task automatic test_loop();
    logic [7:0] v;
    logic [7:0] exp;
    int n = 0;
    r_loop = 1'b1;
    bus_write(ADDR_CMD, 8'h00);
    bus_write(ADDR_DATA, 8'hA5);
    rx_q.push_back(8'hA5);
    v = 8'h00;
    while (!v[ST_RDRF] && n < 3000) begin
      bus_read(ADDR_STATUS, v);
      n++;
    end
    checks++;
    if (v[ST_RDRF] !== 1'b1) begin failures++; $display("FAIL loop_rdrf got=%b exp=1", v[ST_RDRF]); end
    @(negedge clk);
    checks++;
    if (bus.irq_n !== 1'b0) begin failures++; $display("FAIL loop_irq_rx got=%b exp=0", bus.irq_n); end
    bus_read(ADDR_DATA, v);
    exp = rx_q.pop_front();
    checks++;
    if (v !== exp) begin failures++; $display("FAIL loop_data got=%h exp=%h", v, exp); end
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v[ST_RDRF] !== 1'b0) begin failures++; $display("FAIL loop_rdrf_clr got=%b exp=0", v[ST_RDRF]); end
    checks++;
    if (bus.irq_n !== 1'b1) begin failures++; $display("FAIL loop_irq_clr got=%b exp=1", bus.irq_n); end
    bus_write(ADDR_CMD, 8'h04);
    @(negedge clk);
    checks++;
    if (bus.irq_n !== 1'b0) begin failures++; $display("FAIL tx_irq got=%b exp=0", bus.irq_n); end
    bus_write(ADDR_CMD, 8'h02);
    repeat (100) @(negedge clk);
    r_loop = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    logic [7:0] b;
    logic [7:0] exp;
    for (int k = 0; k <= FIFO_DEPTH; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      if (k < FIFO_DEPTH) rx_q.push_back(b);
    end
    repeat (50) @(negedge clk);
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v[ST_OVERRUN] !== 1'b1 || v[ST_RDRF] !== 1'b1) begin
      failures++; $display("FAIL ovr_set got=%h exp=ovr1 rdrf1", v);
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      bus_read(ADDR_DATA, v);
      exp = rx_q.pop_front();
      checks++;
      if (v !== exp) begin failures++; $display("FAIL ovr_data%0d got=%h exp=%h", k, v, exp); end
      if (k == 0) begin
        bus_read(ADDR_STATUS, v);
        checks++;
        if (v[ST_OVERRUN] !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", v[ST_OVERRUN]); end
      end
    end
    bus_read(ADDR_DATA, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL empty_data got=%h exp=00", v); end
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL empty_status got=%h exp=10", v); end
  endtask

  task automatic test_framing_glitch();
    logic [7:0] v;
    logic [7:0] exp;
    send_frame(8'hC3, 1'b0);
    rx_q.push_back(8'hC3);
    repeat (20) @(negedge clk);
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v[ST_FRAMING] !== 1'b1 || v[ST_RDRF] !== 1'b1) begin
      failures++; $display("FAIL frame_set got=%h exp=fe1 rdrf1", v);
    end
    bus_read(ADDR_DATA, v);
    exp = rx_q.pop_front();
    checks++;
    if (v !== exp) begin failures++; $display("FAIL frame_data got=%h exp=%h", v, exp); end
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v[ST_FRAMING] !== 1'b0) begin failures++; $display("FAIL frame_clr got=%b exp=0", v[ST_FRAMING]); end
    repeat (200) @(negedge clk);
    r_rx_drv = 1'b0;
    repeat (4 * CLK_DIV) @(negedge clk);
    r_rx_drv = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL glitch_status got=%h exp=10", v); end
  endtask

  task automatic test_prog_reset();
    logic [7:0] v;
    bus_write(ADDR_CMD, 8'hE9);
    send_frame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    bus_write(ADDR_STATUS, 8'h00);
    bus_read(ADDR_CMD, v);
    checks++;
    if (v !== 8'hE2) begin failures++; $display("FAIL preset_cmd got=%h exp=e2", v); end
    bus_read(ADDR_CTRL, v);
    checks++;
    if (v !== 8'h0F) begin failures++; $display("FAIL preset_ctrl got=%h exp=0f", v); end
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL preset_status got=%h exp=10", v); end
    bus_write(ADDR_CMD, 8'h02);
  endtask

`ifdef ACIA_LOOPBACK_EN
  task automatic test_loopback();
    logic [7:0] v;
    logic [7:0] exp;
    logic saw_low = 1'b0;
    bus_write(ADDR_CMD, 8'h12);
    bus_write(ADDR_DATA, 8'h3C);
    rx_q.push_back(8'h3C);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus.txd !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low !== 1'b0) begin failures++; $display("FAIL lb_txd_idle got=%b exp=0", saw_low); end
    bus_read(ADDR_DATA, v);
    exp = rx_q.pop_front();
    checks++;
    if (v !== exp) begin failures++; $display("FAIL lb_data got=%h exp=%h", v, exp); end
    bus_read(ADDR_CMD, v);
    checks++;
    if (v !== 8'h12) begin failures++; $display("FAIL lb_cmd got=%h exp=12", v); end
    bus_write(ADDR_CMD, 8'h02);
  endtask
`endif

  task automatic test_reset_abort();
    logic [7:0] v;
    int n = 0;
    bus_write(ADDR_DATA, 8'h00);
    while (bus.txd !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    repeat (300) @(negedge clk);
    checks++;
    if (bus.txd !== 1'b0) begin failures++; $display("FAIL abort_midframe got=%b exp=0", bus.txd); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.txd !== 1'b1 || bus.irq_n !== 1'b1) begin
      failures++; $display("FAIL abort_pins got=%b%b exp=11", bus.txd, bus.irq_n);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(ADDR_STATUS, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL abort_status got=%h exp=10", v); end
    bus_read(ADDR_CTRL, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL abort_ctrl got=%h exp=00", v); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_freeze();
    test_back_to_back();
    test_loop();
    test_overrun();
    test_framing_glitch();
    test_prog_reset();
`ifdef ACIA_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
